// File: rtl/backscatter_packetizer.sv
// rtl/backscatter_packetizer.sv - serial packet framer: preamble, sequence header, payload words, optional CRC-16
module backscatter_packetizer #(
  parameter int                       DATA_WIDTH    = 8,
  parameter int                       PAYLOAD_WORDS = 16,
  parameter int                       PREAMBLE_BITS = 16,
  parameter logic [PREAMBLE_BITS-1:0] PREAMBLE      = 16'hA5D3,
  parameter int                       SEQ_WIDTH     = 8,
  parameter bit                       CRC_EN        = 1'b1,
  parameter int                       STALL_TIMEOUT = 1024,
  parameter logic [DATA_WIDTH-1:0]    PAD_WORD      = '0,
  parameter int                       GAP_BITS      = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  trigger,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_re,
  output logic                  output_data,
  output logic                  bit_valid,
  output logic                  packet_done,
  output logic                  underflow,
  output logic [SEQ_WIDTH-1:0]  seq_num
);

  // One left-aligned shifter serves every field; its MSB is the serial output.
  localparam int SW_A = (PREAMBLE_BITS > SEQ_WIDTH) ? PREAMBLE_BITS : SEQ_WIDTH;
  localparam int SW_B = (DATA_WIDTH > 16) ? DATA_WIDTH : 16;
  localparam int SW   = (SW_A > SW_B) ? SW_A : SW_B;
  localparam int PRE_SH  = SW - PREAMBLE_BITS;
  localparam int SEQ_SH  = SW - SEQ_WIDTH;
  localparam int WORD_SH = SW - DATA_WIDTH;
  localparam int CRC_SH  = SW - 16;

  localparam int CW = 16;
  localparam int TW = $clog2(STALL_TIMEOUT + 1);
  localparam int WW = $clog2(PAYLOAD_WORDS + 1);
  localparam logic [CW-1:0] PRE_LAST   = CW'(PREAMBLE_BITS - 1);
  localparam logic [CW-1:0] HDR_LAST   = CW'(SEQ_WIDTH - 1);
  localparam logic [CW-1:0] WORD_LAST  = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] CRC_LAST   = CW'(15);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_BITS - 1);
  localparam logic [TW-1:0] STALL_LAST = TW'(STALL_TIMEOUT - 1);
  localparam logic [WW-1:0] WORDS      = WW'(PAYLOAD_WORDS);

  typedef enum logic [2:0] {
    ST_IDLE, ST_PREAMBLE, ST_HEADER, ST_PAYLOAD, ST_STALL, ST_CRC, ST_GAP
  } state_t;

  state_t                state;
  logic [SW-1:0]         sh;
  logic [CW-1:0]         bit_cnt;
  logic [TW-1:0]         stall_cnt;
  logic [WW-1:0]         words_req;
  logic [WW-1:0]         words_sent;
  logic [DATA_WIDTH-1:0] hold;
  logic                  hold_valid;
  logic                  rd_pend;
  logic [15:0]           crc;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    return (c[15] ^ b) ? ((c << 1) ^ 16'h1021) : (c << 1);
  endfunction

  assign output_data = sh[SW-1];

  always_comb begin
    fifo_re = 1'b0;
    if (reset && trigger && !fifo_empty) begin
      case (state)
        ST_IDLE: fifo_re = 1'b1;
        ST_PREAMBLE, ST_HEADER, ST_PAYLOAD:
          fifo_re = !hold_valid && !rd_pend && (words_req < WORDS);
        ST_STALL:
          fifo_re = !hold_valid && !rd_pend && (words_req < WORDS) && (stall_cnt != STALL_LAST);
        default: fifo_re = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      sh          <= '0;
      bit_valid   <= 1'b0;
      packet_done <= 1'b0;
      underflow   <= 1'b0;
      seq_num     <= '0;
      hold        <= '0;
      hold_valid  <= 1'b0;
      rd_pend     <= 1'b0;
      bit_cnt     <= '0;
      stall_cnt   <= '0;
      words_req   <= '0;
      words_sent  <= '0;
      crc         <= 16'hFFFF;
    end else begin
      packet_done <= 1'b0;
      underflow   <= 1'b0;
      rd_pend     <= fifo_re;
      if (fifo_re) words_req <= words_req + 1'b1;
      if (rd_pend) begin
        hold       <= fifo_data;
        hold_valid <= 1'b1;
      end
      if (state == ST_HEADER || state == ST_PAYLOAD) crc <= crc_step(crc, sh[SW-1]);

      if (!trigger && state != ST_IDLE && state != ST_GAP) begin
        // Window closed: drop the packet, including any word still arriving.
        state      <= ST_IDLE;
        sh         <= '0;
        bit_valid  <= 1'b0;
        hold_valid <= 1'b0;
        rd_pend    <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (fifo_re) begin
              state      <= ST_PREAMBLE;
              sh         <= SW'(PREAMBLE) << PRE_SH;
              bit_valid  <= 1'b1;
              bit_cnt    <= '0;
              crc        <= 16'hFFFF;
              words_req  <= WW'(1);
              words_sent <= '0;
              hold_valid <= 1'b0;
            end
          end
          ST_PREAMBLE: begin
            bit_cnt <= bit_cnt + 1'b1;
            sh      <= sh << 1;
            if (bit_cnt == PRE_LAST) begin
              state   <= ST_HEADER;
              sh      <= SW'(seq_num) << SEQ_SH;
              bit_cnt <= '0;
            end
          end
          ST_HEADER, ST_PAYLOAD: begin
            bit_cnt <= bit_cnt + 1'b1;
            sh      <= sh << 1;
            if (state == ST_PAYLOAD && bit_cnt == WORD_LAST && words_sent == WORDS) begin
              bit_cnt <= '0;
              if (CRC_EN) begin
                state <= ST_CRC;
                sh    <= SW'(crc_step(crc, sh[SW-1])) << CRC_SH;
              end else begin
                state       <= ST_GAP;
                sh          <= '0;
                bit_valid   <= 1'b0;
                packet_done <= 1'b1;
                seq_num     <= seq_num + 1'b1;
              end
            end else if ((state == ST_HEADER && bit_cnt == HDR_LAST) ||
                         (state == ST_PAYLOAD && bit_cnt == WORD_LAST)) begin
              bit_cnt <= '0;
              if (hold_valid) begin
                state      <= ST_PAYLOAD;
                sh         <= SW'(hold) << WORD_SH;
                hold_valid <= 1'b0;
                words_sent <= words_sent + 1'b1;
              end else begin
                state     <= ST_STALL;
                sh        <= '0;
                bit_valid <= 1'b0;
                stall_cnt <= '0;
              end
            end
          end
          ST_STALL: begin
            stall_cnt <= stall_cnt + 1'b1;
            if (hold_valid) begin
              state      <= ST_PAYLOAD;
              sh         <= SW'(hold) << WORD_SH;
              bit_valid  <= 1'b1;
              hold_valid <= 1'b0;
              words_sent <= words_sent + 1'b1;
            end else if (stall_cnt == STALL_LAST) begin
              // The pad occupies a slot, so a late FIFO word goes to the next one.
              state      <= ST_PAYLOAD;
              sh         <= SW'(PAD_WORD) << WORD_SH;
              bit_valid  <= 1'b1;
              underflow  <= 1'b1;
              words_req  <= words_req + 1'b1;
              words_sent <= words_sent + 1'b1;
            end
          end
          ST_CRC: begin
            bit_cnt <= bit_cnt + 1'b1;
            sh      <= sh << 1;
            if (bit_cnt == CRC_LAST) begin
              state       <= ST_GAP;
              sh          <= '0;
              bit_valid   <= 1'b0;
              bit_cnt     <= '0;
              packet_done <= 1'b1;
              seq_num     <= seq_num + 1'b1;
            end
          end
          ST_GAP: begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == GAP_LAST) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_backscatter_packetizer.sv
// tb/tb_backscatter_packetizer.sv - directed and randomized bench for backscatter_packetizer
module tb_backscatter_packetizer;
  localparam int DW = 8, PW = 16, TO = 1024, PLEN = 168;

  logic clock = 1'b0, reset = 1'b0, trigger = 1'b0, fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic fifo_re, output_data, bit_valid, packet_done, underflow;
  logic [7:0] seq_num;

  backscatter_packetizer #(
    .DATA_WIDTH(DW), .PAYLOAD_WORDS(PW), .PREAMBLE_BITS(16), .PREAMBLE(16'hA5D3),
    .SEQ_WIDTH(8), .CRC_EN(1'b1), .STALL_TIMEOUT(TO), .PAD_WORD(8'h00), .GAP_BITS(8)
  ) dut (
    .clock(clock), .reset(reset), .trigger(trigger), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_re(fifo_re), .output_data(output_data),
    .bit_valid(bit_valid), .packet_done(packet_done), .underflow(underflow),
    .seq_num(seq_num)
  );

  always #5 clock = ~clock;

  int checks = 0, failures = 0;
  logic [7:0] fq[$];
  logic [7:0] exp_words[$];
  logic exp_bits[$];
  logic got[$];
  logic logv[$];
  logic s_v, s_b, s_d, s_u, s_re, re0;
  logic [7:0] s_seq, exp_seq, w;
  int done_at, first_v, last_v, ufs, drop_at;
  int stall_pos[$], stall_len[$];
  int sched_at[$];
  logic [7:0] sched_w[$];
  int nre, nv;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] v);
    fq.push_back(v);
    fifo_empty = 1'b0;
  endtask

  // Samples outputs on the falling edge, then plays the FIFO after the rising edge.
  task automatic step();
    @(negedge clock);
    s_v = bit_valid; s_b = output_data; s_d = packet_done;
    s_u = underflow; s_re = fifo_re; s_seq = seq_num;
    @(posedge clock);
    #1;
    if (s_re && fq.size() > 0) fifo_data = fq.pop_front();
    fifo_empty = (fq.size() == 0);
  endtask

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int k = 0; k < 8; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  task automatic build_exp();
    logic [15:0] pre, crc;
    pre = 16'hA5D3;
    exp_bits.delete();
    for (int i = 15; i >= 0; i--) exp_bits.push_back(pre[i]);
    for (int i = 7; i >= 0; i--) exp_bits.push_back(exp_seq[i]);
    crc = crc_byte(16'hFFFF, exp_seq);
    foreach (exp_words[j]) begin
      for (int i = 7; i >= 0; i--) exp_bits.push_back(exp_words[j][i]);
      crc = crc_byte(crc, exp_words[j]);
    end
    for (int i = 15; i >= 0; i--) exp_bits.push_back(crc[i]);
  endtask

  task automatic collect(input int limit);
    int run;
    got.delete(); logv.delete(); stall_pos.delete(); stall_len.delete();
    done_at = -1; first_v = -1; last_v = -1; ufs = 0; run = 0; re0 = 1'b0;
    for (int i = 0; i < limit && done_at < 0; i++) begin
      while (sched_at.size() > 0 && sched_at[0] == i) begin
        void'(sched_at.pop_front());
        push(sched_w.pop_front());
      end
      if (i == drop_at) trigger = 1'b0;
      step();
      logv.push_back(s_v);
      if (i == 0) re0 = s_re;
      if (s_u) ufs++;
      if (s_d) done_at = i;
      if (s_v) begin
        if (first_v < 0) first_v = i;
        if (run > 0) begin
          stall_pos.push_back(got.size());
          stall_len.push_back(run);
        end
        run = 0;
        last_v = i;
        got.push_back(s_b);
      end else if (first_v >= 0 && done_at < 0) run++;
    end
  endtask

  task automatic check_pkt(input string tag);
    int nbad;
    logic [7:0] nxt;
    build_exp();
    chk({tag, "_len"}, got.size(), exp_bits.size());
    nbad = 0;
    for (int i = 0; i < got.size() && i < exp_bits.size(); i++)
      if (got[i] !== exp_bits[i]) nbad++;
    chk({tag, "_bit_errors"}, nbad, 0);
    chk({tag, "_done_after_last_bit"}, done_at, last_v + 1);
    nxt = exp_seq + 8'd1;
    chk({tag, "_seq_next"}, s_seq, nxt);
    exp_seq = nxt;
  endtask

  task automatic new_words(input int n);
    for (int i = 0; i < n; i++) begin
      w = 8'($urandom);
      exp_words.push_back(w);
      push(w);
    end
  endtask

  initial begin
    exp_seq = 8'd0;
    drop_at = -1;

    // Reset state, and no FIFO read while held in reset
    repeat (3) step();
    chk("rst_valid", s_v, 1'b0);
    chk("rst_data", s_b, 1'b0);
    chk("rst_done", s_d, 1'b0);
    chk("rst_underflow", s_u, 1'b0);
    chk("rst_seq", s_seq, 8'd0);
    push(8'h55);
    trigger = 1'b1;
    step();
    chk("rst_fifo_re", s_re, 1'b0);
    trigger = 1'b0;
    fq.delete();
    fifo_empty = 1'b1;
    #2 reset = 1'b1;

    // Trigger with an empty FIFO must not start a packet
    trigger = 1'b1;
    nre = 0; nv = 0;
    repeat (20) begin
      step();
      nre += int'(s_re);
      nv += int'(s_v);
    end
    chk("empty_no_read", nre, 0);
    chk("empty_no_bits", nv, 0);
    trigger = 1'b0;
    step();

    // Prefilled FIFO 0x00..0x0F
    exp_words.delete();
    for (int i = 0; i < 16; i++) begin
      exp_words.push_back(8'(i));
      push(8'(i));
    end
    trigger = 1'b1;
    collect(400);
    chk("t1_accept_read", re0, 1'b1);
    chk("t1_first_bit_cycle", first_v, 1);
    chk("t1_done_cycle", done_at, 169);
    check_pkt("t1");
    nv = 0; nre = 0;
    repeat (8) begin
      step();
      nv += int'(s_v);
      nre += int'(s_d);
    end
    chk("t1_gap_idle", nv, 0);
    chk("t1_single_done", nre, 0);
    trigger = 1'b0;
    step();

    // Three words, refill four at cycle 200 and the rest at 400: stalls only at word edges
    exp_words.delete();
    new_words(3);
    for (int i = 0; i < 13; i++) begin
      w = 8'($urandom);
      exp_words.push_back(w);
      sched_at.push_back(i < 4 ? 200 : 400);
      sched_w.push_back(w);
    end
    trigger = 1'b1;
    collect(3000);
    check_pkt("t2");
    chk("t2_underflow", ufs, 0);
    chk("t2_stall_count", stall_pos.size(), 2);
    if (stall_pos.size() == 2) begin
      chk("t2_stall0_pos", stall_pos[0], 48);
      chk("t2_stall1_pos", stall_pos[1], 80);
    end
    repeat (10) step();
    trigger = 1'b0;
    step();

    // Five words only: each missing word is padded after the full timeout
    exp_words.delete();
    new_words(5);
    for (int i = 0; i < 11; i++) exp_words.push_back(8'h00);
    trigger = 1'b1;
    collect(20000);
    check_pkt("t3");
    chk("t3_underflow_count", ufs, 11);
    chk("t3_stall_count", stall_pos.size(), 11);
    for (int k = 0; k < stall_pos.size() && k < 11; k++) begin
      chk("t3_stall_pos", stall_pos[k], 24 + 8 * (5 + k));
      chk("t3_stall_len", stall_len[k], TO);
    end
    repeat (10) step();
    trigger = 1'b0;
    step();

    // Window closes after 40 bits: no completion, sequence number reused
    exp_words.delete();
    new_words(16);
    trigger = 1'b1;
    drop_at = 40;
    collect(300);
    drop_at = -1;
    chk("t4_bits_sent", got.size(), 40);
    chk("t4_no_done", done_at, -1);
    chk("t4_valid_last", logv[40], 1'b1);
    chk("t4_valid_after", logv[41], 1'b0);
    chk("t4_seq_kept", s_seq, exp_seq);
    build_exp();
    nv = 0;
    for (int i = 0; i < got.size(); i++) if (got[i] !== exp_bits[i]) nv++;
    chk("t4_prefix_errors", nv, 0);
    fq.delete();
    fifo_empty = 1'b1;
    repeat (3) step();
    exp_words.delete();
    new_words(16);
    trigger = 1'b1;
    collect(400);
    check_pkt("t4_retry");
    repeat (10) step();

    // 256 back-to-back packets with random payloads; sequence wraps
    for (int k = 0; k < 256; k++) begin
      exp_words.delete();
      new_words(16);
      collect(400);
      if (k > 0) chk("t5_restart_after_gap", first_v, 8);
      check_pkt("t5");
    end
    repeat (10) step();
    trigger = 1'b0;
    step();

    // Asynchronous reset mid-payload, away from the clock edge
    exp_words.delete();
    new_words(16);
    trigger = 1'b1;
    repeat (30) step();
    #2 reset = 1'b0;
    #1;
    chk("t6_valid", bit_valid, 1'b0);
    chk("t6_data", output_data, 1'b0);
    chk("t6_done", packet_done, 1'b0);
    chk("t6_underflow", underflow, 1'b0);
    chk("t6_seq", seq_num, 8'd0);
    chk("t6_fifo_re", fifo_re, 1'b0);
    repeat (3) begin
      step();
      chk("t6_fifo_re_held", s_re, 1'b0);
    end
    trigger = 1'b0;
    #2 reset = 1'b1;
    fq.delete();
    fifo_empty = 1'b1;
    step();
    exp_seq = 8'd0;
    exp_words.delete();
    new_words(16);
    trigger = 1'b1;
    collect(400);
    check_pkt("t6_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
